// File: rtl/mem_stage_if.sv
// Bundles the execute-side handshake, the data-memory port and the
// memory/writeback register outputs of the memory stage.
interface mem_stage_if;
    // execute -> memory stage
    logic        x_valid;
    logic [31:0] x_alu_result;
    logic [31:0] x_store_data;
    logic [4:0]  x_write_reg_addr;
    logic        x_reg_write;
    logic        x_mem_read;
    logic        x_mem_write;
    logic        x_mem_reg;
    logic        x_ready;

    // data-memory port
    logic [31:0] data_addr;
    logic [31:0] mem_write_data;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_read_data;
    logic        mem_ready;

    // memory/writeback register and status
    logic        mw_valid;
    logic        mw_reg_write;
    logic [4:0]  mw_reg_write_addr;
    logic [31:0] mw_write_data;
    logic        bus_error;

    // upstream stage / memory / register file side
    modport master (
        output x_valid, x_alu_result, x_store_data, x_write_reg_addr,
               x_reg_write, x_mem_read, x_mem_write, x_mem_reg,
               mem_read_data, mem_ready,
        input  x_ready, data_addr, mem_write_data, mem_read, mem_write,
               mw_valid, mw_reg_write, mw_reg_write_addr, mw_write_data,
               bus_error
    );

    // memory stage side
    modport slave (
        input  x_valid, x_alu_result, x_store_data, x_write_reg_addr,
               x_reg_write, x_mem_read, x_mem_write, x_mem_reg,
               mem_read_data, mem_ready,
        output x_ready, data_addr, mem_write_data, mem_read, mem_write,
               mw_valid, mw_reg_write, mw_reg_write_addr, mw_write_data,
               bus_error
    );
endinterface

// File: rtl/mem_stage.sv
// Memory stage of the 5-stage pipeline: holds the XM register, drives the
// data-memory port with wait-state tolerance and abort, and produces the
// MW register that feeds the register-file write port.
module mem_stage #(
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned WAIT_W   = 8
) (
    input logic        clk,
    input logic        rst,
    mem_stage_if.slave bus
);

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;

    logic        xm_valid;
    logic [31:0] xm_alu_result;
    logic [31:0] xm_store_data;
    logic [4:0]  xm_write_reg_addr;
    logic        xm_reg_write;
    logic        xm_mem_read;
    logic        xm_mem_write;
    logic        xm_mem_reg;

    logic        mw_valid;
    logic        mw_reg_write;
    logic [4:0]  mw_reg_write_addr;
    logic [31:0] mw_write_data;
    logic        bus_error;

    logic        xm_mem_op;
    logic        xm_illegal;
    logic        xm_legal;
    logic        in_access;
    logic        abort;
    logic        stall;
    logic        x_legal_mem;
    logic [31:0] retire_data;

    // Decode of the held op, wait-state abort and upstream back-pressure.
    always_comb begin
        xm_mem_op   = xm_valid & (xm_mem_read | xm_mem_write);
        xm_illegal  = xm_valid & ((xm_mem_read & xm_mem_write) |
                                  (xm_mem_op & (xm_alu_result[1:0] != 2'b00)));
        xm_legal    = ~xm_illegal;
        in_access   = (state == ACCESS);
        abort       = in_access & ~bus.mem_ready & (wait_cnt == WAIT_LAST);
        stall       = in_access & ~bus.mem_ready & ~abort;
        x_legal_mem = bus.x_valid & (bus.x_mem_read ^ bus.x_mem_write) &
                      (bus.x_alu_result[1:0] == 2'b00);
        retire_data = (xm_mem_reg & xm_mem_read & xm_legal & ~abort) ?
                      bus.mem_read_data : xm_alu_result;
    end

    // Memory port and MW outputs.
    always_comb begin
        bus.x_ready           = ~stall;
        bus.data_addr         = xm_alu_result;
        bus.mem_write_data    = xm_store_data;
        bus.mem_read          = xm_valid & xm_mem_read  & xm_legal & in_access;
        bus.mem_write         = xm_valid & xm_mem_write & xm_legal & in_access;
        bus.mw_valid          = mw_valid;
        bus.mw_reg_write      = mw_reg_write;
        bus.mw_reg_write_addr = mw_reg_write_addr;
        bus.mw_write_data     = mw_write_data;
        bus.bus_error         = bus_error;
    end

    // Access FSM, XM register, MW register and sticky error flag.
    // A legal memory op enters ACCESS on the same edge it loads into XM, so
    // ACCESS always means "XM holds a legal memory op awaiting mem_ready".
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            wait_cnt          <= '0;
            xm_valid          <= 1'b0;
            xm_alu_result     <= '0;
            xm_store_data     <= '0;
            xm_write_reg_addr <= '0;
            xm_reg_write      <= 1'b0;
            xm_mem_read       <= 1'b0;
            xm_mem_write      <= 1'b0;
            xm_mem_reg        <= 1'b0;
            mw_valid          <= 1'b0;
            mw_reg_write      <= 1'b0;
            mw_reg_write_addr <= '0;
            mw_write_data     <= '0;
            bus_error         <= 1'b0;
        end else if (stall) begin
            wait_cnt     <= wait_cnt + WAIT_W'(1);
            mw_valid     <= 1'b0;
            mw_reg_write <= 1'b0;
        end else begin
            mw_valid          <= xm_valid;
            mw_reg_write      <= xm_valid & xm_reg_write & xm_legal & ~abort;
            mw_reg_write_addr <= xm_write_reg_addr;
            mw_write_data     <= retire_data;
            if (xm_illegal | abort) begin
                bus_error <= 1'b1;
            end

            xm_valid          <= bus.x_valid;
            xm_alu_result     <= bus.x_alu_result;
            xm_store_data     <= bus.x_store_data;
            xm_write_reg_addr <= bus.x_write_reg_addr;
            xm_reg_write      <= bus.x_reg_write;
            xm_mem_read       <= bus.x_mem_read;
            xm_mem_write      <= bus.x_mem_write;
            xm_mem_reg        <= bus.x_mem_reg;
            state             <= x_legal_mem ? ACCESS : IDLE;
            wait_cnt          <= '0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a driver presents instructions and plays a
// wait-state memory, a reference model predicts each retirement, and a
// monitor compares every MW retirement against the predicted queue.
module tb_mem_stage;

    localparam int MAX_WAIT = 15;

    logic clk = 1'b0;
    logic rst;
    mem_stage_if bus();

    mem_stage #(.MAX_WAIT(MAX_WAIT), .WAIT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int edge_cnt = 0;
    bit mon_en = 0;
    bit err_exp = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        logic        valid;
        logic [31:0] alu;
        logic [31:0] sdata;
        logic [4:0]  wa;
        logic        rw;
        logic        rd;
        logic        wr;
        logic        mr;
        int          waits;
    } ins_t;

    typedef struct {
        logic [4:0]  addr;
        logic        reg_write;
        logic [31:0] data;
        bit          chk_data;
        bit          err;
        int          ret_edge;
    } exp_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
    } acc_t;

    exp_t exp_q[$];
    acc_t acc_q[$];

    logic [31:0] ref_mem [1024];
    logic [31:0] dev_mem [1024];

    bit   busy = 0;
    int   cyc  = 0;
    acc_t cur;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: decides the fate of an accepted instruction from the
    // architectural rules and the planned number of memory wait cycles.
    task automatic model_accept(input ins_t i);
        exp_t e;
        acc_t a;
        bit is_mem, illegal, abrt;
        int lat;
        is_mem  = i.rd || i.wr;
        illegal = (i.rd && i.wr) || (is_mem && (i.alu % 4 != 0));
        abrt    = is_mem && !illegal && (i.waits >= MAX_WAIT);
        e.addr      = i.wa;
        e.err       = illegal || abrt;
        e.reg_write = i.rw && !e.err;
        e.chk_data  = !e.err;
        e.data      = (is_mem && !illegal && i.rd && i.mr) ? ref_mem[(i.alu / 4) % 1024] : i.alu;
        if (!is_mem || illegal) lat = 1;
        else if (abrt)          lat = MAX_WAIT;
        else                    lat = i.waits + 1;
        e.ret_edge = edge_cnt + 1 + lat;
        exp_q.push_back(e);
        if (is_mem && !illegal) begin
            a.wr = i.wr; a.addr = i.alu; a.wdata = i.sdata; a.waits = i.waits;
            acc_q.push_back(a);
            if (i.wr && !abrt) ref_mem[(i.alu / 4) % 1024] = i.sdata;
        end
    endtask

    // One pipeline cycle: drive x_*, play the memory device, check x_ready.
    task automatic cycle(input ins_t ins, output bit accepted);
        bit ending;
        bit exp_ready;
        @(negedge clk);
        bus.x_valid          = ins.valid;
        bus.x_alu_result     = ins.alu;
        bus.x_store_data     = ins.sdata;
        bus.x_write_reg_addr = ins.wa;
        bus.x_reg_write      = ins.rw;
        bus.x_mem_read       = ins.rd;
        bus.x_mem_write      = ins.wr;
        bus.x_mem_reg        = ins.mr;
        ending = 0;
        if (!busy && (bus.mem_read || bus.mem_write)) begin
            if (acc_q.size() == 0) begin
                checks++; fails++;
                $display("FAIL unexpected_strobe: got read=%b write=%b expected none", bus.mem_read, bus.mem_write);
            end else begin
                cur = acc_q.pop_front();
                chk("acc_is_write", bus.mem_write, cur.wr);
                chk("acc_is_read", bus.mem_read, !cur.wr);
                chk("acc_addr", bus.data_addr, cur.addr);
                if (cur.wr) chk("acc_wdata", bus.mem_write_data, cur.wdata);
                busy = 1;
                cyc  = 0;
            end
        end else if (busy) begin
            cyc++;
            chk("strobe_held", cur.wr ? bus.mem_write : bus.mem_read, 1);
            chk("strobe_other_low", cur.wr ? bus.mem_read : bus.mem_write, 0);
            chk("acc_addr_held", bus.data_addr, cur.addr);
        end
        if (busy) begin
            bus.mem_ready     = (cyc == cur.waits);
            bus.mem_read_data = dev_mem[cur.addr[11:2]];
            if (bus.mem_ready && cur.wr) dev_mem[cur.addr[11:2]] = cur.wdata;
            ending = bus.mem_ready || (cyc == MAX_WAIT - 1);
        end else begin
            bus.mem_ready     = 1'($urandom_range(0, 1));
            bus.mem_read_data = $urandom;
        end
        #2;
        exp_ready = !busy || ending;
        chk("x_ready", bus.x_ready, exp_ready);
        accepted = bus.x_ready;
        if (accepted && ins.valid) model_accept(ins);
        if (ending) busy = 0;
    endtask

    function automatic ins_t rand_ins();
        ins_t i;
        int k, r;
        k = $urandom_range(0, 7);
        i.valid = 1'b1;
        i.alu   = $urandom;
        i.sdata = $urandom;
        i.wa    = 5'($urandom);
        i.rw    = 1'($urandom);
        i.rd    = 1'b0;
        i.wr    = 1'b0;
        i.mr    = 1'($urandom);
        case (k)
            3, 4: begin i.rd = 1'b1; i.alu = {20'h0, 10'($urandom), 2'b00}; end
            5:    begin i.wr = 1'b1; i.alu = {20'h0, 10'($urandom), 2'b00}; end
            6: begin
                if ($urandom_range(0, 3) == 0) begin
                    i.rd = 1'b1; i.wr = 1'b1; i.alu = {20'h0, 10'($urandom), 2'b00};
                end else begin
                    i.alu = {20'h0, 10'($urandom), 2'($urandom_range(1, 3))};
                    if ($urandom_range(0, 1) == 1) i.rd = 1'b1; else i.wr = 1'b1;
                end
            end
            default: ;
        endcase
        r = $urandom_range(0, 9);
        if (r < 7)      i.waits = $urandom_range(0, 2);
        else if (r < 9) i.waits = $urandom_range(3, 6);
        else            i.waits = $urandom_range(MAX_WAIT - 1, MAX_WAIT);
        return i;
    endfunction

    function automatic ins_t bubble();
        ins_t i;
        i = rand_ins();
        i.valid = 1'b0;
        return i;
    endfunction

    function automatic ins_t mk(input logic [31:0] alu, input logic [31:0] sdata, input logic [4:0] wa,
                                input logic rw, input logic rd, input logic wr, input logic mr, input int waits);
        ins_t i;
        i.valid = 1'b1; i.alu = alu; i.sdata = sdata; i.wa = wa;
        i.rw = rw; i.rd = rd; i.wr = wr; i.mr = mr; i.waits = waits;
        return i;
    endfunction

    task automatic issue(input ins_t ins);
        bit acc;
        int guard;
        guard = 0;
        acc = 0;
        while (!acc && guard < 100) begin
            cycle(ins, acc);
            guard++;
        end
        if (!acc) begin
            checks++; fails++;
            $display("FAIL accept_timeout: got x_ready=0 for %0d cycles expected acceptance", guard);
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int j = 0; j < n; j++) cycle(bubble(), acc);
    endtask

    task automatic drain();
        bit acc;
        int g;
        g = 0;
        while ((exp_q.size() != 0 || busy) && g < 200) begin
            cycle(bubble(), acc);
            g++;
        end
        if (exp_q.size() != 0 || busy) begin
            checks++; fails++;
            $display("FAIL drain_timeout: got %0d pending retirements expected 0", exp_q.size());
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        acc_q.delete();
        busy    = 0;
        err_exp = 0;
    endtask

    task automatic check_reset_state();
        chk("rst_mem_read", bus.mem_read, 0);
        chk("rst_mem_write", bus.mem_write, 0);
        chk("rst_data_addr", bus.data_addr, 0);
        chk("rst_mem_write_data", bus.mem_write_data, 0);
        chk("rst_mw_valid", bus.mw_valid, 0);
        chk("rst_bus_error", bus.bus_error, 0);
        chk("rst_x_ready", bus.x_ready, 1);
    endtask

    // Monitor: every retirement is matched against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (mon_en && bus.mw_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL unexpected_retire: got mw_valid=1 addr=%0d expected no retirement", bus.mw_reg_write_addr);
                end else begin
                    e = exp_q.pop_front();
                    if (e.err) err_exp = 1;
                    chk("retire_edge", edge_cnt, e.ret_edge);
                    chk("mw_reg_write", bus.mw_reg_write, e.reg_write);
                    chk("mw_reg_write_addr", bus.mw_reg_write_addr, e.addr);
                    if (e.chk_data) chk("mw_write_data", bus.mw_write_data, e.data);
                    chk("bus_error", bus.bus_error, err_exp);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no completion expected finish within time limit");
        $fatal(1, "bench did not complete");
    end

    initial begin
        for (int a = 0; a < 1024; a++) begin
            ref_mem[a] = a * 32'h0101_0101 + 32'h5;
            dev_mem[a] = a * 32'h0101_0101 + 32'h5;
        end
        ref_mem[32'h100 / 4] = 32'hDEAD_BEEF;
        dev_mem[32'h100 / 4] = 32'hDEAD_BEEF;

        rst = 1'b1;
        bus.x_valid = 1'b0; bus.x_alu_result = '0; bus.x_store_data = '0;
        bus.x_write_reg_addr = '0; bus.x_reg_write = 1'b0; bus.x_mem_read = 1'b0;
        bus.x_mem_write = 1'b0; bus.x_mem_reg = 1'b0;
        bus.mem_ready = 1'b0; bus.mem_read_data = '0;
        repeat (2) @(negedge clk);
        check_reset_state();
        rst = 1'b0;
        mon_en = 1;

        // ALU op
        issue(mk(32'h0000_0010, 32'h0, 5'd5, 1, 0, 0, 0, 0));
        drain();
        // load with three wait cycles
        issue(mk(32'h0000_0100, 32'h0, 5'd7, 1, 1, 0, 1, 3));
        drain();
        // zero-wait store followed directly by an ALU op
        issue(mk(32'h0000_0200, 32'h1234_5678, 5'd0, 0, 0, 1, 0, 0));
        issue(mk(32'h0000_0ABC, 32'h0, 5'd9, 1, 0, 0, 0, 0));
        drain();
        // misaligned load
        issue(mk(32'h0000_0103, 32'h0, 5'd3, 1, 1, 0, 1, 0));
        drain();
        // last permitted wait, then a stuck memory that aborts
        issue(mk(32'h0000_0200, 32'h0, 5'd4, 1, 1, 0, 1, MAX_WAIT - 1));
        issue(mk(32'h0000_0040, 32'h0, 5'd6, 1, 1, 0, 1, MAX_WAIT));
        drain();

        // reset during the second wait cycle of a load
        issue(mk(32'h0000_0100, 32'h0, 5'd8, 1, 1, 0, 1, 10));
        idle(1);
        @(negedge clk);
        rst = 1'b1;
        bus.x_valid = 1'b0;
        bus.mem_ready = 1'b0;
        clear_model();
        @(negedge clk);
        chk("midrst_mem_read", bus.mem_read, 0);
        chk("midrst_mw_valid", bus.mw_valid, 0);
        chk("midrst_bus_error", bus.bus_error, 0);
        rst = 1'b0;
        issue(mk(32'h0000_0100, 32'h0, 5'd8, 1, 1, 0, 1, 1));
        drain();

        // randomized traffic with bubbles
        for (int n = 0; n < 300; n++) begin
            issue(rand_ins());
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        drain();
        idle(2);
        chk("final_bus_error", bus.bus_error, err_exp);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
